// File: rtl/hdmi_pattern_src_pkg.sv
// Shared definitions for the HDMI pattern source: mode encodings, colour-bar
// table and default 640x480 timing.
package hdmi_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  // {R,G,B} masks: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_TABLE [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/hdmi_pattern_src_if.sv
// Registered video output bus of the pattern source (towards TMDS encoders).
interface hdmi_video_if #(
  parameter int CW = 8
);
  logic          VDE;
  logic [1:0]    CD;
  logic [CW-1:0] R_data;
  logic [CW-1:0] G_data;
  logic [CW-1:0] B_data;
  logic [11:0]   x;
  logic [10:0]   y;
  logic          frame_start;

  modport master (output VDE, CD, R_data, G_data, B_data, x, y, frame_start);
  modport slave  (input  VDE, CD, R_data, G_data, B_data, x, y, frame_start);
endinterface

// File: rtl/hdmi_pattern_src_timing_counter.sv
// Horizontal/vertical raster counters with enable gating plus active/sync
// decode; hs/vs are raw in-window flags, polarity is applied by the user.
module hdmi_timing_counter
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk_fast,
  input  logic        rst_n,
  input  logic        en,
  output logic [11:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        active,
  output logic        hs,
  output logic        vs,
  output logic        frame_wrap
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_last, v_last;

  assign h_last     = (h_cnt == 12'(H_TOTAL - 1));
  assign v_last     = (v_cnt == 11'(V_TOTAL - 1));
  assign frame_wrap = en & h_last & v_last;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

  assign active = (h_cnt < 12'(H_ACTIVE)) && (v_cnt < 11'(V_ACTIVE));
  assign hs     = (h_cnt >= 12'(H_ACTIVE + H_FP)) && (h_cnt < 12'(H_ACTIVE + H_FP + H_SYNC));
  assign vs     = (v_cnt >= 11'(V_ACTIVE + V_FP)) && (v_cnt < 11'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/hdmi_pattern_src.sv
// Parametrised video timing + test-pattern source, one-cycle registered output.
// Optional macro HDMI_PAT_SCROLL_EN: per-frame horizontal scroll for checker/gradient.
module hdmi_pattern_src
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CW         = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic            clk_fast,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] fg_color,
  hdmi_video_if.master    vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int GW      = (CW > 12) ? CW : 12;

  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        active, hs, vs, frame_wrap;

  hdmi_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_fast(clk_fast), .rst_n(rst_n), .en(en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active),
    .hs(hs), .vs(vs), .frame_wrap(frame_wrap)
  );

  function automatic logic [2:0] sat_inc_bar(input logic [2:0] idx);
    return (idx == 3'd7) ? idx : idx + 3'd1;
  endfunction

  mode_e           mode_sh;
  logic [3*CW-1:0] fg_sh;
  logic [11:0]     bar_pix;
  logic [2:0]      bar_idx;
  logic [11:0]     x_eff;

  // Frame-boundary shadows and the divider-free bar tracker follow the counters.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      mode_sh <= MODE_SOLID;
      fg_sh   <= '0;
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (en) begin
      if (frame_wrap) begin
        mode_sh <= mode_e'(mode);
        fg_sh   <= fg_color;
      end
      if (h_cnt == 12'(H_TOTAL - 1)) begin
        bar_pix <= '0;
        bar_idx <= '0;
      end else if (bar_pix == 12'(BAR_W - 1)) begin
        bar_pix <= '0;
        bar_idx <= sat_inc_bar(bar_idx);
      end else begin
        bar_pix <= bar_pix + 12'd1;
      end
    end
  end

`ifdef HDMI_PAT_SCROLL_EN
  logic [11:0] scroll;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) scroll <= '0;
    else if (frame_wrap) scroll <= scroll + 12'd1;
  end

  assign x_eff = h_cnt + scroll;
`else
  assign x_eff = h_cnt;
`endif

  logic [GW-1:0]   xg, yg, xyg;
  logic [2:0]      bar_mask;
  logic [3*CW-1:0] pix_p0;

  assign xg       = GW'(x_eff);
  assign yg       = GW'(v_cnt);
  assign xyg      = xg ^ yg;
  assign bar_mask = BAR_TABLE[bar_idx];

  always_comb begin
    pix_p0 = '0;
    case (mode_sh)
      MODE_SOLID: pix_p0 = fg_sh;
      MODE_BARS:  pix_p0 = {{CW{bar_mask[2]}}, {CW{bar_mask[1]}}, {CW{bar_mask[0]}}};
      MODE_CHECK: pix_p0 = (x_eff[CHECK_LOG2] == v_cnt[CHECK_LOG2]) ? fg_sh : '0;
      MODE_GRAD:  pix_p0 = {xg[CW-1:0], yg[CW-1:0], xyg[CW-1:0]};
      default:    pix_p0 = '0;
    endcase
  end

  logic            vld_p1, fs_p1;
  logic [1:0]      cd_p1;
  logic [3*CW-1:0] rgb_p1;
  logic [11:0]     x_p1;
  logic [10:0]     y_p1;
  logic            show;

  assign show = en & active;

  // p0 -> p1: output register; a paused cycle presents blanking.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      cd_p1  <= {~VS_POL, ~HS_POL};
      rgb_p1 <= '0;
      x_p1   <= '0;
      y_p1   <= '0;
      fs_p1  <= 1'b0;
    end else begin
      vld_p1 <= show;
      cd_p1  <= {(en & vs) ? VS_POL : ~VS_POL, (en & hs) ? HS_POL : ~HS_POL};
      rgb_p1 <= show ? pix_p0 : '0;
      x_p1   <= show ? h_cnt : '0;
      y_p1   <= show ? v_cnt : '0;
      fs_p1  <= show && (h_cnt == 12'd0) && (v_cnt == 11'd0);
    end
  end

  assign vid.VDE         = vld_p1;
  assign vid.CD          = cd_p1;
  assign vid.R_data      = rgb_p1[3*CW-1:2*CW];
  assign vid.G_data      = rgb_p1[2*CW-1:CW];
  assign vid.B_data      = rgb_p1[CW-1:0];
  assign vid.x           = x_p1;
  assign vid.y           = y_p1;
  assign vid.frame_start = fs_p1;

endmodule

// File: tb/tb_hdmi_pattern_src.sv
// Self-checking bench for hdmi_pattern_src on a small 24x12 raster.
module tb_hdmi_pattern_src;
  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic        clk_fast = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic [1:0]  mode     = 2'd0;
  logic [23:0] fg_color = 24'h0;

  hdmi_video_if #(.CW(8)) vid();

  hdmi_pattern_src #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(8), .CHECK_LOG2(2)
  ) dut (
    .clk_fast(clk_fast), .rst_n(rst_n), .en(en),
    .mode(mode), .fg_color(fg_color), .vid(vid)
  );

  always #5 clk_fast = ~clk_fast;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: raster position, frame-latched settings, scroll
  int          mh, mv, moff;
  logic [1:0]  sm;
  logic [23:0] sfg;
  int          cyc = 0;

  logic        e_vde, e_fs;
  logic [1:0]  e_cd;
  logic [23:0] e_rgb;
  int          e_x, e_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int h, input int v, input logic [1:0] md,
                                            input logic [23:0] fg, input int off);
    logic [23:0] bars [8];
    int xe, idx;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    if (!(h < HA && v < VA)) return 24'h0;
    xe = (h + off) % 4096;
    case (md)
      2'd0: return fg;
      2'd1: begin
        idx = h / (HA / 8);
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      2'd2: return (((xe >> 2) & 1) == ((v >> 2) & 1)) ? fg : 24'h0;
      default: return {8'(xe), 8'(v), 8'(xe ^ v)};
    endcase
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; moff = 0; sm = 2'd0; sfg = 24'h0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".vde"}, {31'd0, vid.VDE}, {31'd0, e_vde});
    chk({tag, ".cd"},  {30'd0, vid.CD},  {30'd0, e_cd});
    chk({tag, ".rgb"}, {8'd0, vid.R_data, vid.G_data, vid.B_data}, {8'd0, e_rgb});
    chk({tag, ".x"},   {20'd0, vid.x}, e_x);
    chk({tag, ".y"},   {21'd0, vid.y}, e_y);
    chk({tag, ".fs"},  {31'd0, vid.frame_start}, {31'd0, e_fs});
  endtask

  // One clock: predict from pre-edge model state and inputs, advance model, compare.
  task automatic tick(input string tag);
    int off;
    bit act;
`ifdef HDMI_PAT_SCROLL_EN
    off = moff;
`else
    off = 0;
`endif
    act = (mh < HA) && (mv < VA);
    if (en) begin
      e_vde = act;
      e_cd  = {!(mv >= VA + VF && mv < VA + VF + VSW), !(mh >= HA + HF && mh < HA + HF + HSW)};
      e_rgb = act ? model_rgb(mh, mv, sm, sfg, off) : 24'h0;
      e_x   = act ? mh : 0;
      e_y   = act ? mv : 0;
      e_fs  = act && mh == 0 && mv == 0;
      if (mh == HT - 1 && mv == VT - 1) begin
        sm = mode; sfg = fg_color; moff = (moff + 1) % 4096;
      end
      mh = (mh + 1) % HT;
      if (mh == 0) mv = (mv + 1) % VT;
    end else begin
      e_vde = 1'b0; e_cd = 2'b11; e_rgb = 24'h0; e_x = 0; e_y = 0; e_fs = 1'b0;
    end
    @(posedge clk_fast);
    @(negedge clk_fast);
    cyc++;
    check_outputs(tag);
  endtask

  int run, prev_fs, fs_at;
  bit found;

  initial begin
    // Reset state
    rst_n = 1'b0; en = 1'b1; mode = 2'd0; fg_color = 24'hFF0000;
    model_reset();
    repeat (3) @(negedge clk_fast);
    e_vde = 0; e_cd = 2'b11; e_rgb = 0; e_x = 0; e_y = 0; e_fs = 0;
    check_outputs("reset");
    rst_n = 1'b1;

    // Timing and mode latch over three frames
    run = 0; prev_fs = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == FRAME + 3 * HT) mode = 2'd1;
      tick("timing");
      if (i == 0) chk("first_fs", {31'd0, vid.frame_start}, 32'd1);
      if (vid.VDE) run++;
      else if (run > 0) begin chk("vde_run", run, 16); run = 0; end
      if (vid.frame_start) begin
        if (prev_fs >= 0) chk("fs_period", cyc - prev_fs, FRAME);
        prev_fs = cyc;
      end
      if (i >= FRAME + 3 * HT && i < 2 * FRAME && vid.VDE)
        chk("latch_hold", {8'd0, vid.R_data, vid.G_data, vid.B_data}, 32'hFF0000);
      if (i >= 2 * FRAME && vid.VDE && vid.y == 0) begin
        if (vid.x == 0 || vid.x == 1)
          chk("bar_white", {8'd0, vid.R_data, vid.G_data, vid.B_data}, 32'hFFFFFF);
        if (vid.x == 14 || vid.x == 15)
          chk("bar_black", {8'd0, vid.R_data, vid.G_data, vid.B_data}, 32'h000000);
      end
    end

    // Checkerboard, square size 4
    mode = 2'd2; fg_color = 24'h00FF00;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick("check");
`ifndef HDMI_PAT_SCROLL_EN
      if (i >= FRAME && vid.VDE) begin
        if (vid.x == 0 && vid.y == 0) chk("chk_0_0", {24'd0, vid.G_data}, 32'hFF);
        if (vid.x == 4 && vid.y == 0)
          chk("chk_4_0", {8'd0, vid.R_data, vid.G_data, vid.B_data}, 32'h0);
        if (vid.x == 4 && vid.y == 4) chk("chk_4_4", {24'd0, vid.G_data}, 32'hFF);
      end
`endif
    end

    // Pause for 10 cycles at h_cnt=5 of line 2
    mode = 2'd3;
    tick("pause_pre");
    chk("pause_fs0", {31'd0, vid.frame_start}, 32'd1);
    fs_at = cyc;
    found = 0;
    for (int i = 0; i < FRAME && !found; i++) begin
      if (mh == 5 && mv == 2) found = 1;
      else tick("pause_seek");
    end
    chk("pause_seek_found", {31'd0, found}, 32'd1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick("paused");
      chk("pause_vde", {31'd0, vid.VDE}, 32'd0);
      chk("pause_cd", {30'd0, vid.CD}, 32'd3);
    end
    en = 1'b1;
    tick("resume");
    chk("resume_x", {20'd0, vid.x}, 32'd5);
    chk("resume_y", {21'd0, vid.y}, 32'd2);
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick("pause_post");
      if (vid.frame_start) found = 1;
    end
    chk("pause_fs_found", {31'd0, found}, 32'd1);
    chk("pause_fs_period", cyc - fs_at, FRAME + 10);

    // Asynchronous reset mid-frame at output (7,3)
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick("areset_seek");
      if (vid.VDE && vid.x == 7 && vid.y == 3) found = 1;
    end
    chk("areset_seek_found", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    e_vde = 0; e_cd = 2'b11; e_rgb = 0; e_x = 0; e_y = 0; e_fs = 0;
    check_outputs("areset_now");
    @(negedge clk_fast);
    rst_n = 1'b1;
    model_reset();
    tick("areset_after");
    chk("areset_first_fs", {31'd0, vid.frame_start}, 32'd1);

    // Frame 2 after reset in gradient mode: R at x=0 shows the scroll offset
    for (int i = 0; i < 2 * FRAME - 1; i++) tick("scroll");
    tick("scroll_f2");
`ifdef HDMI_PAT_SCROLL_EN
    chk("scroll_r_x0", {24'd0, vid.R_data}, 32'h02);
`else
    chk("scroll_r_x0", {24'd0, vid.R_data}, 32'h00);
`endif

    // Randomized run: pauses, mode and colour changes at arbitrary cycles
    for (int i = 0; i < 2500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) fg_color = 24'($urandom);
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
